// File: rtl/load_store_unit.sv
// Load/store unit: computes the effective address, runs one bus transaction per
// operation, aligns load data into the register file and reports faults.
module load_store_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        op_valid,
  output logic        op_ready,
  input  logic        op_is_store,
  input  logic [1:0]  op_size,
  input  logic        op_unsigned,
  input  logic [4:0]  op_rd,
  input  logic [31:0] op_base,
  input  logic [31:0] op_imm,
  input  logic [31:0] op_wdata,
  output logic        busy,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  input  logic        mem_err,
  output logic        wb_we,
  output logic [4:0]  wb_addr,
  output logic [31:0] wb_data,
  output logic        op_done,
  output logic        fault_valid,
  output logic [1:0]  fault_code,
  output logic [31:0] fault_addr
);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_RESP, S_WB, S_FAULT} state_t;

  state_t      state, state_nxt;
  logic [31:0] ea_q, wdata_q, ld_q, cnt_q, fault_addr_q;
  logic [1:0]  size_q, fault_code_q;
  logic        uns_q, store_q;
  logic [4:0]  rd_q;
  logic [3:0]  be_q;

  logic [31:0] ea_nxt, wdata_nxt, rd_shift, ld_ext;
  logic [3:0]  be_nxt;
  logic        accept, misaligned, timeout, fault_set;
  logic [1:0]  fault_code_set;

  assign accept  = op_valid && (state == S_IDLE);
  assign ea_nxt  = op_base + op_imm;
  assign timeout = (cnt_q == TIMEOUT_CYCLES - 1);

  always_comb begin
    misaligned = 1'b0;
    be_nxt     = 4'b1111;
    wdata_nxt  = op_wdata;
    unique case (op_size)
      2'b00: begin
        if (op_is_store) be_nxt = 4'b0001 << ea_nxt[1:0];
        wdata_nxt = {4{op_wdata[7:0]}};
      end
      2'b01: begin
        misaligned = ea_nxt[0];
        if (op_is_store) be_nxt = 4'b0011 << ea_nxt[1:0];
        wdata_nxt = {2{op_wdata[15:0]}};
      end
      default: misaligned = |ea_nxt[1:0];
    endcase
  end

  // Lane extraction: shift the addressed byte/half down to bit 0, then extend.
  assign rd_shift = mem_rdata >> {ea_q[1:0], 3'b000};
  always_comb begin
    unique case (size_q)
      2'b00:   ld_ext = uns_q ? {24'h0, rd_shift[7:0]} : {{24{rd_shift[7]}}, rd_shift[7:0]};
      2'b01:   ld_ext = uns_q ? {16'h0, rd_shift[15:0]} : {{16{rd_shift[15]}}, rd_shift[15:0]};
      default: ld_ext = mem_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // A response arriving on the final counted cycle completes the op rather than timing out.
  always_comb begin
    state_nxt      = state;
    fault_set      = 1'b0;
    fault_code_set = 2'b00;
    unique case (state)
      S_IDLE: if (accept) begin
        if (misaligned) begin
          state_nxt      = S_FAULT;
          fault_set      = 1'b1;
          fault_code_set = 2'b01;
        end else begin
          state_nxt = S_REQ;
        end
      end
      S_REQ: begin
        if (timeout) begin
          state_nxt      = S_FAULT;
          fault_set      = 1'b1;
          fault_code_set = 2'b11;
        end else if (mem_gnt) begin
          state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        if (mem_rvalid && !mem_err) begin
          state_nxt = S_WB;
        end else if (mem_rvalid) begin
          state_nxt      = S_FAULT;
          fault_set      = 1'b1;
          fault_code_set = 2'b10;
        end else if (timeout) begin
          state_nxt      = S_FAULT;
          fault_set      = 1'b1;
          fault_code_set = 2'b11;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    op_ready    = (state == S_IDLE);
    busy        = (state != S_IDLE);
    mem_req     = (state == S_REQ);
    mem_we      = (state == S_REQ) && store_q;
    mem_be      = (state == S_REQ) ? be_q : '0;
    mem_addr    = {ea_q[31:2], 2'b00};
    mem_wdata   = wdata_q;
    wb_we       = (state == S_WB) && !store_q && (rd_q != '0);
    wb_addr     = rd_q;
    wb_data     = ld_q;
    op_done     = (state == S_WB) || (state == S_FAULT);
    fault_valid = (state == S_FAULT);
    fault_code  = fault_code_q;
    fault_addr  = fault_addr_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ea_q         <= '0;
      wdata_q      <= '0;
      be_q         <= '0;
      size_q       <= '0;
      uns_q        <= 1'b0;
      store_q      <= 1'b0;
      rd_q         <= '0;
      cnt_q        <= '0;
      ld_q         <= '0;
      fault_code_q <= '0;
      fault_addr_q <= '0;
    end else begin
      if (accept) begin
        ea_q    <= ea_nxt;
        wdata_q <= wdata_nxt;
        be_q    <= be_nxt;
        size_q  <= op_size;
        uns_q   <= op_unsigned;
        store_q <= op_is_store;
        rd_q    <= op_rd;
        cnt_q   <= '0;
      end else if (state == S_REQ || state == S_RESP) begin
        cnt_q <= cnt_q + 32'd1;
      end
      if (state == S_RESP && mem_rvalid && !mem_err && !store_q) ld_q <= ld_ext;
      if (fault_set) begin
        fault_code_q <= fault_code_set;
        fault_addr_q <= (state == S_IDLE) ? ea_nxt : ea_q;
      end
    end
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, giving the maximum cycles spent in REQ+RESP before a timeout fault.
REQ-002 SHALL have port clk  in  1  sole clock, all state on rising edge.
REQ-003 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port op_valid  in  1  execute presents a memory operation.
REQ-005 SHALL have port op_ready  out  1  unit idle; op accepted when op_valid && op_ready.
REQ-006 SHALL have ports op_is_store in 1, op_size in 2 (00 byte, 01 half, 10 word), op_unsigned in 1, op_rd in 5.
REQ-007 SHALL have ports op_base in 32 (rs1 data), op_imm in 32 (sign-extended offset), op_wdata in 32 (rs2 data).
REQ-008 SHALL have port busy  out  1  high whenever state != IDLE; the core holds PC while high.
REQ-009 SHALL have bus outputs mem_req 1, mem_we 1, mem_addr 32 (word-aligned), mem_be 4, mem_wdata 32.
REQ-010 SHALL have bus inputs mem_gnt 1, mem_rvalid 1, mem_rdata 32, mem_err 1 (qualified by mem_rvalid).
REQ-011 SHALL have writeback outputs wb_we 1, wb_addr 5, wb_data 32, driving the register file write port.
REQ-012 SHALL have outputs op_done 1 (one-cycle pulse), fault_valid 1 (one-cycle pulse), fault_code 2 (01 misaligned, 10 bus error, 11 timeout), fault_addr 32.

Function
REQ-013 SHALL compute ea = (op_base + op_imm) mod 2^32 at acceptance and register ea, size, unsigned, rd, store flag and store data.
REQ-014 SHALL implement FSM states IDLE, REQ, RESP, WB, FAULT; op_ready = (state == IDLE).
REQ-015 SHALL go IDLE->FAULT on acceptance when misaligned (half with ea[0]=1, word with ea[1:0]!=00, size 11 treated as word); no bus request issued.
REQ-016 SHALL otherwise go IDLE->REQ on acceptance; mem_req first asserts the cycle after acceptance.
REQ-017 SHALL hold mem_req and all mem_* outputs stable in REQ until mem_gnt, then go to RESP with mem_req low the following cycle.
REQ-018 SHALL drive mem_addr = {ea[31:2],2'b00}; loads mem_we=0, mem_be=1111.
REQ-019 SHALL for stores drive mem_be = 0001<<ea[1:0] (byte), 0011<<ea[1:0] (half), 1111 (word); mem_wdata = byte replicated x4, half replicated x2, or word.
REQ-020 SHALL in RESP on mem_rvalid with mem_err=0 capture the lane-extracted, sign- or zero-extended (op_unsigned) load data and go to WB.
REQ-021 SHALL in RESP on mem_rvalid with mem_err=1 go to FAULT with code 10.
REQ-022 SHALL count cycles in REQ+RESP; when count reaches TIMEOUT_CYCLES without completion, go to FAULT with code 11 and drop mem_req.
REQ-023 SHALL in WB pulse op_done for one cycle; for loads with rd != 0 also pulse wb_we with wb_addr=rd and wb_data=extracted value; then return to IDLE.
REQ-024 SHALL never assert wb_we for stores, rd = 0, or faulting operations.
REQ-025 SHALL in FAULT pulse fault_valid and op_done for one cycle with fault_addr = ea, then return to IDLE.
REQ-026 SHALL ignore mem_gnt, mem_rvalid and mem_err outside REQ/RESP (late responses after a timeout are discarded).
REQ-027 SHALL accept mem_gnt and mem_rvalid in the same cycle only if the bus asserts rvalid no earlier than the cycle after gnt; rvalid in REQ is ignored.
REQ-028 SHALL allow back-to-back operations: a new op accepted the cycle after op_done at the earliest.

Reset
REQ-029 SHALL, on rst_n low at any time including mid-transaction, immediately force state IDLE, timeout count 0, and all outputs 0 except op_ready=1 after deassertion.
REQ-030 SHALL leave wb_data, mem_addr, mem_wdata, fault_addr, fault_code at 0 after reset until the next operation.

Verification
REQ-031 Load word: base=0x1000, imm=4, gnt cycle 1, rvalid cycle 3 rdata=0xDEADBEEF, rd=5 -> wb_we pulse, wb_addr=5, wb_data=0xDEADBEEF, op_done once.
REQ-032 Load byte signed: ea=0x2003, rdata=0x80FFFFFF -> wb_data=0xFFFFFF80; same with op_unsigned=1 -> 0x00000080.
REQ-033 Store half: ea=0x3002, op_wdata=0x1234ABCD -> mem_addr=0x3000, mem_be=1100, mem_wdata=0xABCDABCD, mem_we=1, no wb_we.
REQ-034 Misaligned word: ea=0x4001 -> no mem_req, fault_valid with code 01, fault_addr=0x4001, op_done one cycle after acceptance.
REQ-035 Timeout: TIMEOUT_CYCLES=8, mem_gnt never asserted -> mem_req held 8 cycles then dropped, fault code 11; later rvalid ignored.
REQ-036 Reset mid-RESP: rst_n low while waiting for rvalid -> mem_req=0, busy=0 immediately; after release op_ready=1 and next load completes normally.
